ysyx_23060077_wb_arbiter: RTL and testbench

YSYX_23060077_WB_ARBITER -- requirements
Module: ysyx_23060077_wb_arbiter

---
 rtl/ysyx_23060077_wb_arbiter_if.sv | 49 ++++
 rtl/ysyx_23060077_wb_arbiter.sv | 117 +++++++++++
 tb/tb_ysyx_23060077_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060077_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060077_wb_arbiter_if
// Bundles the writeback arbiter's bus signals.
//   ALU request  : alu_valid, alu_rd_addr, alu_rd_data -> alu_ready
//   LSU request  : lsu_valid, lsu_rd_addr, lsu_rd_data -> lsu_ready
//   Issue check  : issue_en, issue_rd_addr             -> issue_ready
//   Hazard query : rs1_addr, rs2_addr                  -> rs1_busy, rs2_busy
//   RF write     : reg_rd_en, reg_rd_addr, reg_rd_data (arbiter output)
// Modports: master = pipeline side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface ysyx_23060077_wb_arbiter_if #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  alu_valid;
    logic [REG_WIDTH-1:0]  alu_rd_addr;
    logic [DATA_WIDTH-1:0] alu_rd_data;
    logic                  alu_ready;
    logic                  lsu_valid;
    logic [REG_WIDTH-1:0]  lsu_rd_addr;
    logic [DATA_WIDTH-1:0] lsu_rd_data;
    logic                  lsu_ready;
    logic                  issue_en;
    logic [REG_WIDTH-1:0]  issue_rd_addr;
    logic                  issue_ready;
    logic [REG_WIDTH-1:0]  rs1_addr;
    logic [REG_WIDTH-1:0]  rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  reg_rd_en;
    logic [REG_WIDTH-1:0]  reg_rd_addr;
    logic [DATA_WIDTH-1:0] reg_rd_data;

    modport master (
        output alu_valid, alu_rd_addr, alu_rd_data,
        output lsu_valid, lsu_rd_addr, lsu_rd_data,
        output issue_en, issue_rd_addr, rs1_addr, rs2_addr,
        input  alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy,
        input  reg_rd_en, reg_rd_addr, reg_rd_data
    );

    modport slave (
        input  alu_valid, alu_rd_addr, alu_rd_data,
        input  lsu_valid, lsu_rd_addr, lsu_rd_data,
        input  issue_en, issue_rd_addr, rs1_addr, rs2_addr,
        output alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy,
        output reg_rd_en, reg_rd_addr, reg_rd_data
    );
endinterface

// File: rtl/ysyx_23060077_wb_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_23060077_wb_arbiter
// Shares one register-file write port between the ALU and the LSU with
// round-robin arbitration, and keeps a pending-write scoreboard used for
// WAW issue blocking and RAW source-busy queries.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : ysyx_23060077_wb_arbiter_if.slave (requests, issue, queries,
//           registered register-file write port)
// ----------------------------------------------------------------------------
module ysyx_23060077_wb_arbiter #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input logic                        clock,
    input logic                        reset,
    ysyx_23060077_wb_arbiter_if.slave  bus
);
    localparam int NUM_REGS = 1 << REG_WIDTH;
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;
    localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};
    localparam logic [REG_WIDTH-1:0] ZERO_ADDR = {REG_WIDTH{1'b0}};

    logic                  last_grant_r;
    logic [NUM_REGS-1:0]   pending_r;
    logic [NUM_REGS-1:0]   pending_nxt_s;
    logic [NUM_REGS-1:0]   clr_mask_s;
    logic [NUM_REGS-1:0]   set_mask_s;
    logic                  alu_grant_s;
    logic                  lsu_grant_s;
    logic                  xfer_s;
    logic [REG_WIDTH-1:0]  xfer_addr_s;
    logic [DATA_WIDTH-1:0] xfer_data_s;
    logic                  issue_ready_s;
    logic                  issue_set_s;
    logic                  reg_rd_en_r;
    logic [REG_WIDTH-1:0]  reg_rd_addr_r;
    logic [DATA_WIDTH-1:0] reg_rd_data_r;

    // Round-robin grant: on a conflict the requester not served last wins.
    always_comb begin
        alu_grant_s = 1'b0;
        lsu_grant_s = 1'b0;
        if (bus.alu_valid && bus.lsu_valid) begin
            if (last_grant_r == GRANT_LSU) begin
                alu_grant_s = 1'b1;
            end else begin
                lsu_grant_s = 1'b1;
            end
        end else begin
            alu_grant_s = bus.alu_valid;
            lsu_grant_s = bus.lsu_valid;
        end
    end

    // Payload of the granted requester.
    always_comb begin
        xfer_s = alu_grant_s | lsu_grant_s;
        if (lsu_grant_s) begin
            xfer_addr_s = bus.lsu_rd_addr;
            xfer_data_s = bus.lsu_rd_data;
        end else begin
            xfer_addr_s = bus.alu_rd_addr;
            xfer_data_s = bus.alu_rd_data;
        end
    end

    // Scoreboard update: the clear is applied before the set so a same-cycle
    // issue to the address being written keeps the bit pending.
    always_comb begin
        issue_ready_s = ~pending_r[bus.issue_rd_addr];
        issue_set_s   = bus.issue_en & issue_ready_s & (bus.issue_rd_addr != ZERO_ADDR);
        clr_mask_s    = xfer_s ? (ONE_HOT0 << xfer_addr_s) : {NUM_REGS{1'b0}};
        set_mask_s    = issue_set_s ? (ONE_HOT0 << bus.issue_rd_addr) : {NUM_REGS{1'b0}};
        // Register 0 is never tracked.
        pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;
    end

    // Arbitration pointer and pending-write scoreboard.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_r <= GRANT_LSU;
            pending_r    <= {NUM_REGS{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
            if (xfer_s) begin
                last_grant_r <= lsu_grant_s ? GRANT_LSU : GRANT_ALU;
            end
        end
    end

    // Registered register-file write port; writes to x0 are swallowed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_rd_en_r   <= 1'b0;
            reg_rd_addr_r <= ZERO_ADDR;
            reg_rd_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            reg_rd_en_r <= xfer_s && (xfer_addr_s != ZERO_ADDR);
            if (xfer_s) begin
                reg_rd_addr_r <= xfer_addr_s;
                reg_rd_data_r <= xfer_data_s;
            end
        end
    end

    assign bus.alu_ready   = alu_grant_s;
    assign bus.lsu_ready   = lsu_grant_s;
    assign bus.issue_ready = issue_ready_s;
    assign bus.rs1_busy    = pending_r[bus.rs1_addr];
    assign bus.rs2_busy    = pending_r[bus.rs2_addr];
    assign bus.reg_rd_en   = reg_rd_en_r;
    assign bus.reg_rd_addr = reg_rd_addr_r;
    assign bus.reg_rd_data = reg_rd_data_r;
endmodule

// File: tb/tb_ysyx_23060077_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060077_wb_arbiter
// Self-checking bench: a directed vector table, a reset-in-flight sequence and
// a randomized run checked against a behavioural scoreboard model.
// ----------------------------------------------------------------------------
module tb_ysyx_23060077_wb_arbiter;
    localparam int RW = 5;
    localparam int DW = 32;

    typedef struct {
        logic          av;  logic [RW-1:0] aa; logic [DW-1:0] ad;
        logic          lv;  logic [RW-1:0] la; logic [DW-1:0] ld;
        logic          ie;  logic [RW-1:0] ia;
        logic [RW-1:0] r1;  logic [RW-1:0] r2;
        logic          e_ar; logic e_lr; logic e_ir; logic e_b1; logic e_b2;
        logic          e_en; logic [RW-1:0] e_addr; logic [DW-1:0] e_data;
    } vec_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    ysyx_23060077_wb_arbiter_if #(.REG_WIDTH(RW), .DATA_WIDTH(DW)) bus ();

    ysyx_23060077_wb_arbiter #(.REG_WIDTH(RW), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic av, input logic [RW-1:0] aa, input logic [DW-1:0] ad,
                         input logic lv, input logic [RW-1:0] la, input logic [DW-1:0] ld,
                         input logic ie, input logic [RW-1:0] ia,
                         input logic [RW-1:0] r1, input logic [RW-1:0] r2);
        bus.alu_valid = av; bus.alu_rd_addr = aa; bus.alu_rd_data = ad;
        bus.lsu_valid = lv; bus.lsu_rd_addr = la; bus.lsu_rd_data = ld;
        bus.issue_en = ie;  bus.issue_rd_addr = ia;
        bus.rs1_addr = r1;  bus.rs2_addr = r2;
    endtask

    task automatic do_reset();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    function automatic vec_t v(input logic av, input logic [RW-1:0] aa, input logic [DW-1:0] ad,
                               input logic lv, input logic [RW-1:0] la, input logic [DW-1:0] ld,
                               input logic ie, input logic [RW-1:0] ia,
                               input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                               input logic ar, input logic lr, input logic ir,
                               input logic b1, input logic b2,
                               input logic en, input logic [RW-1:0] ea, input logic [DW-1:0] ed);
        vec_t t;
        t.av = av; t.aa = aa; t.ad = ad; t.lv = lv; t.la = la; t.ld = ld;
        t.ie = ie; t.ia = ia; t.r1 = r1; t.r2 = r2;
        t.e_ar = ar; t.e_lr = lr; t.e_ir = ir; t.e_b1 = b1; t.e_b2 = b2;
        t.e_en = en; t.e_addr = ea; t.e_data = ed;
        return t;
    endfunction

    vec_t tbl [25];

    // Behavioural model state for the random phase.
    bit            m_pend [32];
    bit            m_last_lsu;
    logic          a_req, l_req;
    logic [RW-1:0] a_addr, l_addr, i_addr, q1, q2, w_addr;
    logic [DW-1:0] a_data, l_data, w_data;
    logic          i_en, g_alu, g_lsu, e_ir, e_en;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        do_reset();

        // Reset state.
        chk("rst_en",   32'(bus.reg_rd_en),   32'd0);
        chk("rst_addr", 32'(bus.reg_rd_addr), 32'd0);
        chk("rst_data", bus.reg_rd_data,      32'd0);
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd13, 5'd1, 5'd31);
        #1;
        chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("rst_rs1_busy",    32'(bus.rs1_busy),    32'd0);
        chk("rst_rs2_busy",    32'(bus.rs2_busy),    32'd0);
        @(negedge clock);

        //            av aa    ad         lv la    ld         ie ia    r1    r2    ar lr ir b1 b2 en ea    ed
        tbl[0]  = v(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd3, 5'd3, 5'd4, 0, 0, 1, 0, 0, 0, 5'd0, 32'h0);
        tbl[1]  = v(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd4, 5'd3, 5'd4, 0, 0, 1, 1, 0, 0, 5'd0, 32'h0);
        tbl[2]  = v(1, 5'd3, 32'hA0,   1, 5'd4, 32'hB0,   0, 5'd0, 5'd3, 5'd4, 1, 0, 1, 1, 1, 1, 5'd3, 32'hA0);
        tbl[3]  = v(1, 5'd3, 32'hA1,   1, 5'd4, 32'hB0,   0, 5'd0, 5'd3, 5'd4, 0, 1, 1, 0, 1, 1, 5'd4, 32'hB0);
        tbl[4]  = v(1, 5'd3, 32'hA1,   1, 5'd4, 32'hB1,   0, 5'd0, 5'd3, 5'd4, 1, 0, 1, 0, 0, 1, 5'd3, 32'hA1);
        tbl[5]  = v(1, 5'd3, 32'hA2,   1, 5'd4, 32'hB1,   0, 5'd0, 5'd3, 5'd4, 0, 1, 1, 0, 0, 1, 5'd4, 32'hB1);
        tbl[6]  = v(1, 5'd3, 32'hA2,   0, 5'd0, 32'h0,    1, 5'd5, 5'd5, 5'd3, 1, 0, 1, 0, 0, 1, 5'd3, 32'hA2);
        tbl[7]  = v(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0,    0, 5'd0, 5'd5, 5'd0, 1, 0, 1, 1, 0, 1, 5'd5, 32'h1234);
        tbl[8]  = v(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd5, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 32'h0);
        tbl[9]  = v(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd7, 5'd7, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 32'h0);
        tbl[10] = v(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0, 32'h0);
        tbl[11] = v(0, 5'd0, 32'h0,    1, 5'd7, 32'h77,   0, 5'd0, 5'd7, 5'd0, 0, 1, 1, 1, 0, 1, 5'd7, 32'h77);
        tbl[12] = v(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd7, 5'd7, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 32'h0);
        tbl[13] = v(0, 5'd0, 32'h0,    1, 5'd7, 32'h78,   0, 5'd0, 5'd7, 5'd0, 0, 1, 1, 1, 0, 1, 5'd7, 32'h78);
        tbl[14] = v(0, 5'd0, 32'h0,    1, 5'd9, 32'h99,   1, 5'd9, 5'd0, 5'd9, 0, 1, 1, 0, 0, 1, 5'd9, 32'h99);
        tbl[15] = v(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd9, 0, 0, 1, 0, 1, 0, 5'd0, 32'h0);
        tbl[16] = v(1, 5'd9, 32'h9A,   0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd9, 1, 0, 1, 0, 1, 1, 5'd9, 32'h9A);
        tbl[17] = v(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd9, 0, 0, 1, 0, 0, 0, 5'd0, 32'h0);
        tbl[18] = v(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'h0,    1, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 0, 5'd0, 32'h0);
        tbl[19] = v(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 32'h0);
        tbl[20] = v(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 32'h0);
        tbl[21] = v(1, 5'd2, 32'h22,   1, 5'd6, 32'h66,   0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 1, 5'd6, 32'h66);
        tbl[22] = v(1, 5'd2, 32'h22,   0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 1, 5'd2, 32'h22);
        tbl[23] = v(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 32'h0);
        tbl[24] = v(1, 5'd2, 32'h23,   1, 5'd6, 32'h67,   0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 1, 5'd6, 32'h67);

        for (int i = 0; i < 25; i++) begin
            apply(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld,
                  tbl[i].ie, tbl[i].ia, tbl[i].r1, tbl[i].r2);
            #1;
            chk($sformatf("tbl%0d_alu_ready", i),   32'(bus.alu_ready),   32'(tbl[i].e_ar));
            chk($sformatf("tbl%0d_lsu_ready", i),   32'(bus.lsu_ready),   32'(tbl[i].e_lr));
            chk($sformatf("tbl%0d_issue_ready", i), 32'(bus.issue_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_rs1_busy", i),    32'(bus.rs1_busy),    32'(tbl[i].e_b1));
            chk($sformatf("tbl%0d_rs2_busy", i),    32'(bus.rs2_busy),    32'(tbl[i].e_b2));
            @(posedge clock);
            #1;
            chk($sformatf("tbl%0d_reg_rd_en", i), 32'(bus.reg_rd_en), 32'(tbl[i].e_en));
            if (tbl[i].e_en) begin
                chk($sformatf("tbl%0d_reg_rd_addr", i), 32'(bus.reg_rd_addr), 32'(tbl[i].e_addr));
                chk($sformatf("tbl%0d_reg_rd_data", i), bus.reg_rd_data, tbl[i].e_data);
            end
            @(negedge clock);
        end

        // Reset asserted in the cycle after a transfer.
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd0, 5'd0);
        @(negedge clock);
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 5'd0, 5'd0);
        @(negedge clock);
        apply(1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd11, 5'd11, 5'd10);
        #1;
        chk("rst_seq_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst_seq_rs1_busy",  32'(bus.rs1_busy),  32'd1);
        chk("rst_seq_rs2_busy",  32'(bus.rs2_busy),  32'd1);
        @(posedge clock);
        #1;
        chk("rst_seq_pulse", 32'(bus.reg_rd_en), 32'd1);
        bus.alu_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_seq_en_cleared",  32'(bus.reg_rd_en),   32'd0);
        chk("rst_seq_addr_zero",   32'(bus.reg_rd_addr), 32'd0);
        chk("rst_seq_data_zero",   bus.reg_rd_data,      32'd0);
        chk("rst_seq_rs1_idle",    32'(bus.rs1_busy),    32'd0);
        chk("rst_seq_issue_ready", 32'(bus.issue_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("rst_seq_no_pulse", 32'(bus.reg_rd_en), 32'd0);
            @(negedge clock);
        end
        // Pointer comes out of reset favouring the ALU.
        apply(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("rst_ptr_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst_ptr_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        @(posedge clock);
        #1;
        chk("rst_ptr_addr", 32'(bus.reg_rd_addr), 32'd12);
        @(negedge clock);

        // Randomized run against the scoreboard model.
        do_reset();
        for (int k = 0; k < 32; k++) m_pend[k] = 1'b0;
        m_last_lsu = 1'b1;
        a_req = 1'b0; l_req = 1'b0;
        a_addr = 5'd0; l_addr = 5'd0; a_data = 32'd0; l_data = 32'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!a_req && $urandom_range(0, 3) != 0) begin
                a_req = 1'b1; a_addr = 5'($urandom_range(0, 31)); a_data = $urandom;
            end
            if (!l_req && $urandom_range(0, 3) != 0) begin
                l_req = 1'b1; l_addr = 5'($urandom_range(0, 31)); l_data = $urandom;
            end
            i_en   = 1'($urandom_range(0, 1));
            i_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            q1     = 5'($urandom_range(0, 31));
            q2     = 5'($urandom_range(0, 31));
            apply(a_req, a_addr, a_data, l_req, l_addr, l_data, i_en, i_addr, q1, q2);

            // Lone requester wins; on a clash the one not served last wins.
            g_alu = a_req && (!l_req || m_last_lsu);
            g_lsu = l_req && !g_alu;
            e_ir  = !m_pend[i_addr];
            #1;
            chk("rnd_alu_ready",   32'(bus.alu_ready),   32'(g_alu));
            chk("rnd_lsu_ready",   32'(bus.lsu_ready),   32'(g_lsu));
            chk("rnd_issue_ready", 32'(bus.issue_ready), 32'(e_ir));
            chk("rnd_rs1_busy",    32'(bus.rs1_busy),    32'(m_pend[q1]));
            chk("rnd_rs2_busy",    32'(bus.rs2_busy),    32'(m_pend[q2]));

            e_en = 1'b0; w_addr = 5'd0; w_data = 32'd0;
            if (g_alu || g_lsu) begin
                w_addr = g_alu ? a_addr : l_addr;
                w_data = g_alu ? a_data : l_data;
                e_en   = (w_addr != 5'd0);
                m_pend[w_addr] = 1'b0;
                m_last_lsu = g_lsu;
            end
            if (i_en && e_ir && i_addr != 5'd0) m_pend[i_addr] = 1'b1;

            @(posedge clock);
            #1;
            chk("rnd_reg_rd_en", 32'(bus.reg_rd_en), 32'(e_en));
            if (e_en) begin
                chk("rnd_reg_rd_addr", 32'(bus.reg_rd_addr), 32'(w_addr));
                chk("rnd_reg_rd_data", bus.reg_rd_data, w_data);
            end
            if (g_alu) a_req = 1'b0;
            if (g_lsu) l_req = 1'b0;
            @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
